// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the control unit (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_rd, req_wr, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req_rd, req_wr, addr, wdata,
    output busy, done, err, rdata
  );

endinterface

// File: rtl/data_mem_responder.sv
// Multicycle word data memory: accepts one ld/sd at a time, waits WAIT_CYCLES, commits,
// then pulses done with registered read data or an error flag.
module data_mem_responder #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              reject;
  logic              mem_we;

  // Access legality is judged only from the values latched at accept.
  assign idx          = addr_q[IDX_W+2:3];
  assign misaligned   = addr_q[2:0] != 3'b000;
  assign out_of_range = addr_q[ADDR_W-1:IDX_W+3] != '0;
  assign reject       = (rd_q & wr_q) | misaligned | out_of_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_rd | bus.req_wr) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rd_d    = bus.req_rd;
          wr_d    = bus.req_wr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit edge: the write lands before RESP so a following read sees it.
          state_d = ST_RESP;
          err_d   = reject;
          mem_we  = wr_q & ~reject;
          if (rd_q && !reject) begin
            rdata_d = mem_q[idx];
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.busy  = state_q != ST_IDLE;
  assign bus.done  = state_q == ST_RESP;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (WAIT_CYCLES 0, 2, 15) share clock and
// reset; a select steers the request to one build and muxes its outputs back.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        reqRd;
  logic        reqWr;
  logic [63:0] addr;
  logic [63:0] wdata;
  int          sel;

  int checkCount;
  int errorCount;
  int doneCnt0;
  int doneCnt2;
  int doneCnt15;

  data_mem_responder_if #(.DATA_W(64), .ADDR_W(64)) bus0 ();
  data_mem_responder_if #(.DATA_W(64), .ADDR_W(64)) bus2 ();
  data_mem_responder_if #(.DATA_W(64), .ADDR_W(64)) bus15 ();

  data_mem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  data_mem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );
  data_mem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(256), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset), .bus(bus15.slave)
  );

  assign bus0.req_rd  = reqRd & (sel == 0);
  assign bus0.req_wr  = reqWr & (sel == 0);
  assign bus0.addr    = addr;
  assign bus0.wdata   = wdata;
  assign bus2.req_rd  = reqRd & (sel == 2);
  assign bus2.req_wr  = reqWr & (sel == 2);
  assign bus2.addr    = addr;
  assign bus2.wdata   = wdata;
  assign bus15.req_rd = reqRd & (sel == 15);
  assign bus15.req_wr = reqWr & (sel == 15);
  assign bus15.addr   = addr;
  assign bus15.wdata  = wdata;

  logic        obsBusy;
  logic        obsDone;
  logic        obsErr;
  logic [63:0] obsRdata;

  always_comb begin
    obsBusy  = bus2.busy;
    obsDone  = bus2.done;
    obsErr   = bus2.err;
    obsRdata = bus2.rdata;
    if (sel == 0) begin
      obsBusy  = bus0.busy;
      obsDone  = bus0.done;
      obsErr   = bus0.err;
      obsRdata = bus0.rdata;
    end else if (sel == 15) begin
      obsBusy  = bus15.busy;
      obsDone  = bus15.done;
      obsErr   = bus15.err;
      obsRdata = bus15.rdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters used to prove that no extra responses appear.
  always @(posedge clk) begin
    if (bus0.done)  doneCnt0++;
    if (bus2.done)  doneCnt2++;
    if (bus15.done) doneCnt15++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request (called #1 after a rising edge), checks latency and the response,
  // then checks the cycle after the pulse.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [63:0] a, input logic [63:0] d,
                               input logic expErr, input logic [63:0] expRdata, input int expLat);
    int lat;
    lat   = 0;
    reqRd = rd;
    reqWr = wr;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    reqRd = 1'b0;
    reqWr = 1'b0;
    checkOutput({tag, ":busy"}, 64'(obsBusy), 64'd1);
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!obsDone && lat < 40);
    checkOutput({tag, ":latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ":err"}, 64'(obsErr), 64'(expErr));
    checkOutput({tag, ":rdata"}, obsRdata, expRdata);
    @(posedge clk);
    #1;
    checkOutput({tag, ":doneLow"}, 64'(obsDone), 64'd0);
    checkOutput({tag, ":errLow"}, 64'(obsErr), 64'd0);
    checkOutput({tag, ":idle"}, 64'(obsBusy), 64'd0);
    checkOutput({tag, ":held"}, obsRdata, expRdata);
  endtask

  localparam logic [63:0] BEEF = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] W20  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W08  = 64'h0808_0808_0808_0808;
  localparam logic [63:0] W18  = 64'h5555_AAAA_5555_AAAA;

  initial begin
    int snap;
    checkCount = 0;
    errorCount = 0;
    doneCnt0   = 0;
    doneCnt2   = 0;
    doneCnt15  = 0;
    sel   = 2;
    reqRd = 1'b0;
    reqWr = 1'b0;
    addr  = '0;
    wdata = '0;
    reset = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst:busy", 64'(obsBusy), 64'd0);
    checkOutput("rst:done", 64'(obsDone), 64'd0);
    checkOutput("rst:err", 64'(obsErr), 64'd0);
    checkOutput("rst:rdata", obsRdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle:busy", 64'(obsBusy), 64'd0);
    checkOutput("idle:done", 64'(obsDone), 64'd0);
    checkOutput("idle:err", 64'(obsErr), 64'd0);
    checkOutput("idle:rdata", obsRdata, 64'd0);

    // WAIT_CYCLES=2: write then read back, errors, and a rejected dual request.
    applyStimulus("wr10", 1'b0, 1'b1, 64'h10, BEEF, 1'b0, 64'd0, 3);
    applyStimulus("rd10", 1'b1, 1'b0, 64'h10, 64'd0, 1'b0, BEEF, 3);
    applyStimulus("wr20", 1'b0, 1'b1, 64'h20, W20, 1'b0, BEEF, 3);
    applyStimulus("rd13", 1'b1, 1'b0, 64'h13, 64'd0, 1'b1, BEEF, 3);
    applyStimulus("rd800", 1'b1, 1'b0, 64'h800, 64'd0, 1'b1, BEEF, 3);
    applyStimulus("rdwr20", 1'b1, 1'b1, 64'h20, 64'hBAD, 1'b1, BEEF, 3);
    applyStimulus("rd20", 1'b1, 1'b0, 64'h20, 64'd0, 1'b0, W20, 3);

    // Busy filtering: req_wr toggles through WAIT and RESP and must be ignored.
    applyStimulus("wr08", 1'b0, 1'b1, 64'h08, W08, 1'b0, W20, 3);
    snap  = doneCnt2;
    reqRd = 1'b1;
    addr  = 64'h08;
    @(posedge clk);
    #1;
    reqRd = 1'b0;
    wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      reqWr = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    checkOutput("filt:done", 64'(obsDone), 64'd1);
    checkOutput("filt:rdata", obsRdata, W08);
    reqWr = 1'b1;
    @(posedge clk);
    #1;
    reqWr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("filt:pulses", 64'(doneCnt2 - snap), 64'd1);
    checkOutput("filt:idle", 64'(obsBusy), 64'd0);
    applyStimulus("rd08", 1'b1, 1'b0, 64'h08, 64'd0, 1'b0, W08, 3);

    // Reset during WAIT of a write must abandon it.
    applyStimulus("wr18", 1'b0, 1'b1, 64'h18, W18, 1'b0, W08, 3);
    snap  = doneCnt2;
    reqWr = 1'b1;
    addr  = 64'h18;
    wdata = 64'h1234;
    @(posedge clk);
    #1;
    reqWr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst:busyBefore", 64'(obsBusy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst:busy", 64'(obsBusy), 64'd0);
    checkOutput("midrst:rdata", obsRdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst:noDone", 64'(doneCnt2 - snap), 64'd0);
    applyStimulus("rd18", 1'b1, 1'b0, 64'h18, 64'd0, 1'b0, W18, 3);

    // Latency extremes, back-to-back requests with rdata held between pulses.
    sel = 0;
    applyStimulus("w0:wr0", 1'b0, 1'b1, 64'h0, 64'hA0A0, 1'b0, 64'd0, 1);
    applyStimulus("w0:wr8", 1'b0, 1'b1, 64'h8, 64'hB8B8, 1'b0, 64'd0, 1);
    applyStimulus("w0:rd0", 1'b1, 1'b0, 64'h0, 64'd0, 1'b0, 64'hA0A0, 1);
    applyStimulus("w0:rd8", 1'b1, 1'b0, 64'h8, 64'd0, 1'b0, 64'hB8B8, 1);
    checkOutput("w0:pulses", 64'(doneCnt0), 64'd4);
    sel = 15;
    applyStimulus("w15:wr0", 1'b0, 1'b1, 64'h0, 64'hC0C0, 1'b0, 64'd0, 16);
    applyStimulus("w15:wr8", 1'b0, 1'b1, 64'h8, 64'hD8D8, 1'b0, 64'd0, 16);
    applyStimulus("w15:rd0", 1'b1, 1'b0, 64'h0, 64'd0, 1'b0, 64'hC0C0, 16);
    applyStimulus("w15:rd8", 1'b1, 1'b0, 64'h8, 64'd0, 1'b0, 64'hD8D8, 16);
    checkOutput("w15:pulses", 64'(doneCnt15), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
